// File: rtl/tmc_nios2_irq_ctrl.sv
// Interrupt aggregator: sync, latch, mask, prioritise irq_in -> irq.
// Optional IRQ_HOLDOFF_EN adds a post-ack holdoff counter at address 6.
module tmc_nios2_irq_ctrl #(
  parameter int          NUM_IRQ     = 4,
  parameter int          SYNC_STAGES = 2,
  parameter logic [15:0] MODE_RESET  = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               chipselect,
  input  logic [2:0]         address,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               irq
);

  localparam int N = NUM_IRQ;

  logic                        wr_en;
  logic [N-1:0]                wdat;
  logic                        unused_wd;

  logic [SYNC_STAGES-1:0][N-1:0] sync_q, sync_d;
  logic [N-1:0] s;
  logic [N-1:0] prev_q, prev_d;
  logic [N-1:0] pend_q, pend_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] mode_q, mode_d;
  logic [N-1:0] pending, active;
  logic [N-1:0] set, clr, frc;
  logic [3:0]   act_idx;
  logic         act_vld;
  logic         irq_q, irq_d;
  logic [15:0]  rdata_q, rdata_d;
  logic [15:0]  hold_rd;
  logic         irq_ok;

  logic wr_status, wr_mask, wr_mode, wr_force, wr_hold;

  assign wr_en     = chipselect & ~write_n;
  assign wdat      = writedata[N-1:0];
  assign unused_wd = ^writedata;

  assign wr_status = wr_en && (address == 3'd0);
  assign wr_mask   = wr_en && (address == 3'd1);
  assign wr_mode   = wr_en && (address == 3'd2);
  assign wr_force  = wr_en && (address == 3'd5);
  assign wr_hold   = wr_en && (address == 3'd6);

  // Synchroniser shift chain; last stage is the clean source view
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = irq_in;
    for (int i = 1; i < SYNC_STAGES; i++)
      sync_d[i] = sync_q[i-1];
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Edge latching, set beats clear; level bits hold 0 here
  always_comb begin
    prev_d  = s;
    clr     = wr_status ? wdat : '0;
    frc     = wr_force ? wdat : '0;
    set     = (s & ~prev_q) | frc;
    pend_d  = mode_q & ((pend_q & ~clr) | set);
    mask_d  = wr_mask ? wdat : mask_q;
    mode_d  = wr_mode ? wdat : mode_q;
    pending = (mode_q & pend_q) | (~mode_q & s);
    active  = pending & mask_q;
  end

  // Lowest-numbered active source wins
  always_comb begin
    act_idx = 4'd0;
    act_vld = |active;
    for (int i = N - 1; i >= 0; i--)
      if (active[i]) act_idx = 4'(i);
  end

`ifdef IRQ_HOLDOFF_EN
  logic [15:0] hold_q, hold_d;
  logic [15:0] hcnt_q, hcnt_d;

  // Holdoff reload on any non-empty ack, else count down to 0
  always_comb begin
    hold_d = wr_hold ? writedata : hold_q;
    if (wr_status && (|wdat))
      hcnt_d = hold_q;
    else if (hcnt_q != 16'd0)
      hcnt_d = hcnt_q - 16'd1;
    else
      hcnt_d = 16'd0;
    hold_rd = hold_q;
    irq_ok  = (hcnt_q == 16'd0);
  end

  // Holdoff registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_q <= 16'd0;
      hcnt_q <= 16'd0;
    end else begin
      hold_q <= hold_d;
      hcnt_q <= hcnt_d;
    end
  end
`else
  logic unused_hold;
  assign unused_hold = wr_hold;

  // No holdoff: irq never suppressed
  always_comb begin
    hold_rd = 16'd0;
    irq_ok  = 1'b1;
  end
`endif

  // Interrupt output and register read mux
  always_comb begin
    irq_d = act_vld & irq_ok;
    unique case (address)
      3'd0:    rdata_d = 16'(pending);
      3'd1:    rdata_d = 16'(mask_q);
      3'd2:    rdata_d = 16'(mode_q);
      3'd3:    rdata_d = 16'(s);
      3'd4:    rdata_d = act_vld ? {1'b1, 11'd0, act_idx} : 16'd0;
      3'd6:    rdata_d = hold_rd;
      default: rdata_d = 16'd0;
    endcase
  end

  // State registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      mode_q  <= MODE_RESET[N-1:0];
      irq_q   <= 1'b0;
      rdata_q <= 16'd0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      irq_q   <= irq_d;
      rdata_q <= rdata_d;
    end
  end

  assign irq      = irq_q;
  assign readdata = rdata_q;

endmodule

// File: tb/tb_tmc_nios2_irq_ctrl.sv
// Directed bench for tmc_nios2_irq_ctrl (NUM_IRQ=4, SYNC_STAGES=2).
// Define IRQ_HOLDOFF_EN to also exercise the holdoff counter.
module tb_tmc_nios2_irq_ctrl;

  logic        clk;
  logic        reset_n;
  logic        chipselect;
  logic [2:0]  address;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic [3:0]  irq_in;
  logic        irq;

  int n_chk;
  int n_err;
  logic [15:0] v;

  tmc_nios2_irq_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .address    (address),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq_in     (irq_in),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [15:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    d          = readdata;
    chipselect = 1'b0;
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {15'd0, irq}, {15'd0, exp});
  endtask

  initial begin
    n_chk      = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    chipselect = 1'b0;
    address    = 3'd0;
    write_n    = 1'b1;
    writedata  = 16'd0;
    irq_in     = 4'd0;

    // reset with toggling inputs
    for (int i = 0; i < 4; i++) begin
      irq_in = (i % 2 == 0) ? 4'hF : 4'h0;
      tick();
    end
    chk_irq("rst_irq", 1'b0);
    chk("rst_rdata", readdata, 16'd0);
    irq_in = 4'd0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    rd(3'd0, v); chk("rst_status", v, 16'h0000);
    rd(3'd1, v); chk("rst_mask", v, 16'h0000);
    rd(3'd2, v); chk("rst_mode", v, 16'h000F);
    rd(3'd3, v); chk("rst_raw", v, 16'h0000);
    rd(3'd4, v); chk("rst_active", v, 16'h0000);
    rd(3'd5, v); chk("rst_force", v, 16'h0000);
    rd(3'd6, v); chk("rst_hold", v, 16'h0000);
    rd(3'd7, v); chk("rst_a7", v, 16'h0000);
    chk_irq("rst_irq2", 1'b0);

    // edge latency and ack
    wr(3'd1, 16'h0001);
    irq_in = 4'b0001;
    tick();
    irq_in = 4'b0000;
    tick();
    tick();
    chk_irq("edge_early", 1'b0);
    tick();
    chk_irq("edge_lat", 1'b1);
    rd(3'd0, v); chk("edge_status", v, 16'h0001);
    rd(3'd4, v); chk("edge_active", v, 16'h8000);
    wr(3'd0, 16'h0001);
    tick();
    chk_irq("ack_irq", 1'b0);
    rd(3'd0, v); chk("ack_status", v, 16'h0000);
    rd(3'd4, v); chk("ack_active", v, 16'h0000);

    // priority
    wr(3'd1, 16'h000F);
    irq_in = 4'b1010;
    tick();
    irq_in = 4'b0000;
    repeat (4) tick();
    chk_irq("pri_irq", 1'b1);
    rd(3'd4, v); chk("pri_act31", v, 16'h8001);
    wr(3'd0, 16'h0002);
    rd(3'd4, v); chk("pri_act3", v, 16'h8003);
    wr(3'd0, 16'h0008);
    irq_in = 4'b0010;
    tick();
    irq_in = 4'b0000;
    repeat (4) tick();
    wr(3'd1, 16'h0008);
    tick();
    tick();
    chk_irq("pri_masked", 1'b0);
    rd(3'd4, v); chk("pri_act_none", v, 16'h0000);
    rd(3'd0, v); chk("pri_status", v, 16'h0002);
    wr(3'd0, 16'h000F);

    // set/clear collision
    wr(3'd1, 16'h0004);
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    repeat (4) tick();
    chk_irq("col_pre", 1'b1);
    irq_in = 4'b0100;
    tick();
    irq_in = 4'b0000;
    tick();
    address    = 3'd0;
    writedata  = 16'h0004;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
    tick();
    chk_irq("col_irq1", 1'b1);
    tick();
    chk_irq("col_irq2", 1'b1);
    rd(3'd0, v); chk("col_status", v, 16'h0004);
    wr(3'd0, 16'h0004);
    tick();
    chk_irq("col_ack", 1'b0);

    // level mode
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0002);
    irq_in = 4'b0010;
    tick();
    tick();
    chk_irq("lvl_early", 1'b0);
    tick();
    chk_irq("lvl_lat", 1'b1);
    wr(3'd0, 16'h0002);
    tick();
    chk_irq("lvl_noack", 1'b1);
    rd(3'd0, v); chk("lvl_status", v, 16'h0002);
    rd(3'd3, v); chk("lvl_raw", v, 16'h0002);
    irq_in = 4'b0000;
    tick();
    tick();
    chk_irq("lvl_hold", 1'b1);
    tick();
    chk_irq("lvl_drop", 1'b0);
    wr(3'd5, 16'h0002);
    tick();
    tick();
    chk_irq("lvl_force", 1'b0);
    rd(3'd0, v); chk("lvl_force_st", v, 16'h0000);

    // level->edge with input already high: no edge
    irq_in = 4'b0010;
    repeat (3) tick();
    wr(3'd2, 16'h000F);
    repeat (2) tick();
    rd(3'd0, v); chk("mode_sw_st", v, 16'h0000);
    chk_irq("mode_sw_irq", 1'b0);
    irq_in = 4'b0000;

    // force in edge mode
    wr(3'd1, 16'h0001);
    wr(3'd5, 16'h0001);
    tick();
    chk_irq("frc_irq", 1'b1);
    rd(3'd0, v); chk("frc_status", v, 16'h0001);

    // mid-operation reset
    reset_n = 1'b0;
    #1;
    chk_irq("mrst_irq", 1'b0);
    chk("mrst_rdata", readdata, 16'h0000);
    tick();
    reset_n = 1'b1;
    tick();
    rd(3'd0, v); chk("mrst_status", v, 16'h0000);
    rd(3'd1, v); chk("mrst_mask", v, 16'h0000);

`ifdef IRQ_HOLDOFF_EN
    // holdoff after ack
    wr(3'd1, 16'h0001);
    wr(3'd6, 16'd10);
    rd(3'd6, v); chk("ho_reg", v, 16'd10);
    wr(3'd5, 16'h0001);
    tick();
    chk_irq("ho_pre", 1'b1);
    wr(3'd0, 16'h0001);
    wr(3'd5, 16'h0001);
    chk_irq("ho_c1", 1'b0);
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_irq("ho_low", 1'b0);
    end
    tick();
    chk_irq("ho_rise", 1'b1);
    wr(3'd6, 16'd0);
    wr(3'd0, 16'h0001);
    wr(3'd5, 16'h0001);
    chk_irq("ho0_c1", 1'b0);
    tick();
    chk_irq("ho0_rise", 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
